// File: rtl/key_digit_ctrl_if.sv
// Key/switch inputs and digit outputs of the button-driven digit source.
interface key_digit_ctrl_if;
    logic [3:0] KEY;      // raw push buttons, active-low
    logic [3:0] SW;       // load value
    logic [3:0] number;   // active-low digit
    logic       changed;  // one-cycle pulse on every applied command

    modport master (
        output KEY,
        output SW,
        input  number,
        input  changed
    );

    modport slave (
        input  KEY,
        input  SW,
        output number,
        output changed
    );
endinterface

// File: rtl/key_digit_ctrl.sv
// Button-driven 4-bit digit: synchronizes and debounces four active-low keys,
// applies clear/load/decrement/increment commands and auto-repeats held steps.
module key_digit_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input logic             CLOCK_50,
    input logic             reset,
    key_digit_ctrl_if.slave bus
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic [3:0]    key_s1, key_s2, sw_s1, sw_s2;
    logic [1:0]    sync_vld;
    logic [3:0]    deb_q, deb_prev_q, block_q;
    logic [DW-1:0] deb_cnt_q [4];
    logic [3:0]    press, rel;

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          dir_q, dir_d;       // 1 = decrement
    logic [3:0]    number_q, number_d; // holds ~count
    logic          changed_q, changed_d;
    logic [3:0]    count, step_val;
    logic          dir_release;

    // Two-flop synchronizers; sync_vld marks when key_s2 reflects real samples.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_s1   <= 4'hF;
            key_s2   <= 4'hF;
            sw_s1    <= 4'h0;
            sw_s2    <= 4'h0;
            sync_vld <= 2'b00;
        end else begin
            key_s1   <= bus.KEY;
            key_s2   <= key_s1;
            sw_s1    <= bus.SW;
            sw_s2    <= sw_s1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // Per-key debounce filter, edge history, and post-reset press blocking.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            deb_q      <= 4'hF;
            deb_prev_q <= 4'hF;
            block_q    <= 4'hF;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            deb_prev_q <= deb_q;
            // A key only becomes usable once it has been seen released after reset.
            block_q    <= block_q & ~({4{sync_vld[1]}} & key_s2);
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_q[i]     <= ~deb_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press       = deb_prev_q & ~deb_q & ~block_q;
    assign rel         = ~deb_prev_q & deb_q;
    assign count       = ~number_q;
    assign step_val    = dir_q ? (count - 4'd1) : (count + 4'd1);
    assign dir_release = dir_q ? rel[1] : rel[0];

    // Command arbitration and repeat FSM next-state.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        dir_d     = dir_q;
        number_d  = number_q;
        changed_d = 1'b0;
        if (press[3]) begin
            number_d  = 4'hF;
            changed_d = 1'b1;
            state_d   = StIdle;
            t_d       = '0;
        end else if (press[2]) begin
            number_d  = ~sw_s2;
            changed_d = 1'b1;
            state_d   = StIdle;
            t_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press[1]) begin
                        number_d  = ~(count - 4'd1);
                        changed_d = 1'b1;
                        dir_d     = 1'b1;
                        state_d   = StHold;
                        t_d       = '0;
                    end else if (press[0]) begin
                        number_d  = ~(count + 4'd1);
                        changed_d = 1'b1;
                        dir_d     = 1'b0;
                        state_d   = StHold;
                        t_d       = '0;
                    end
                end
                StHold: begin
                    if (dir_release) begin
                        state_d = StIdle;
                        t_d     = '0;
                    end else if (t_q == HOLD_LAST) begin
                        number_d  = ~step_val;
                        changed_d = 1'b1;
                        state_d   = StRepeat;
                        t_d       = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (dir_release) begin
                        state_d = StIdle;
                        t_d     = '0;
                    end else if (t_q == REP_LAST) begin
                        number_d  = ~step_val;
                        changed_d = 1'b1;
                        t_d       = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    t_d     = '0;
                end
            endcase
        end
    end

    // Command register: FSM state, timer, direction and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            t_q       <= '0;
            dir_q     <= 1'b0;
            number_q  <= 4'hF;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            dir_q     <= dir_d;
            number_q  <= number_d;
            changed_q <= changed_d;
        end
    end

    assign bus.number  = number_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_key_digit_ctrl.sv
// Directed bench for key_digit_ctrl with short debounce/hold/repeat times.
module tb_key_digit_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   chg_cnt = 0;

    key_digit_ctrl_if bus ();

    key_digit_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One clock; sample 1 time unit after the rising edge and tally changed pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.changed === 1'b1) chg_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.KEY = 4'hF;
        ticks(3);
        rst = 1'b0;
        ticks(4);
    endtask

    task automatic press(input int k, input int hold);
        bus.KEY[k] = 1'b0;
        ticks(hold);
        bus.KEY[k] = 1'b1;
        ticks(12);
    endtask

    task automatic test_reset();
        ticks(2);
        checks++;
        if (bus.number !== 4'hF) begin
            errors++; $display("FAIL reset_number: got %h expected %h", bus.number, 4'hF);
        end
        checks++;
        if (bus.changed !== 1'b0) begin
            errors++; $display("FAIL reset_changed: got %b expected 0", bus.changed);
        end
        rst = 1'b0;
        ticks(4);
        checks++;
        if (bus.number !== 4'hF) begin
            errors++; $display("FAIL post_reset_number: got %h expected %h", bus.number, 4'hF);
        end
        checks++;
        if (chg_cnt !== 0) begin
            errors++; $display("FAIL post_reset_changed: got %0d pulses expected 0", chg_cnt);
        end
    endtask

    task automatic test_single_press();
        int c0;
        c0 = chg_cnt;
        bus.KEY[0] = 1'b0;
        ticks(6);
        checks++;
        if (bus.number !== 4'hF) begin
            errors++; $display("FAIL press_early: got %h expected %h", bus.number, 4'hF);
        end
        tick();
        checks++;
        if (bus.number !== 4'hE || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL press_latency: got number %h changed %b expected number e changed 1",
                     bus.number, bus.changed);
        end
        ticks(3);
        bus.KEY[0] = 1'b1;
        ticks(12);
        checks++;
        if (bus.number !== 4'hE) begin
            errors++; $display("FAIL press_final: got %h expected %h", bus.number, 4'hE);
        end
        checks++;
        if (chg_cnt - c0 !== 1) begin
            errors++; $display("FAIL press_pulses: got %0d expected 1", chg_cnt - c0);
        end
    endtask

    task automatic test_auto_repeat();
        int         idx[$];
        logic [3:0] val[$];
        int         exp_t[4];
        logic [3:0] exp_n[4];
        exp_t = '{7, 27, 35, 43};
        exp_n = '{4'hE, 4'hD, 4'hC, 4'hB};
        do_reset();
        bus.KEY[0] = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (bus.changed === 1'b1) begin
                idx.push_back(i);
                val.push_back(bus.number);
            end
            if (i == 39) bus.KEY[0] = 1'b1;
        end
        checks++;
        if (idx.size() !== 4) begin
            errors++; $display("FAIL repeat_count: got %0d steps expected 4", idx.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= idx.size()) begin
                errors++; $display("FAIL repeat_step%0d: got no step expected tick %0d", k, exp_t[k]);
            end else if (idx[k] !== exp_t[k] || val[k] !== exp_n[k]) begin
                errors++;
                $display("FAIL repeat_step%0d: got tick %0d number %h expected tick %0d number %h",
                         k, idx[k], val[k], exp_t[k], exp_n[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int c0;
        bus.SW = 4'hF;
        ticks(3);
        press(2, 10);
        checks++;
        if (bus.number !== 4'h0) begin
            errors++; $display("FAIL wrap_load15: got %h expected %h", bus.number, 4'h0);
        end
        c0 = chg_cnt;
        press(0, 10);
        checks++;
        if (bus.number !== 4'hF || chg_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL wrap_inc: got number %h pulses %0d expected number f pulses 1",
                     bus.number, chg_cnt - c0);
        end
        c0 = chg_cnt;
        press(1, 10);
        checks++;
        if (bus.number !== 4'h0 || chg_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL wrap_dec: got number %h pulses %0d expected number 0 pulses 1",
                     bus.number, chg_cnt - c0);
        end
    endtask

    task automatic test_load_priority();
        int c0;
        bus.SW = 4'h9;
        ticks(3);
        c0 = chg_cnt;
        bus.KEY = 4'hA;  // KEY[2] and KEY[0] pressed together
        ticks(10);
        bus.KEY = 4'hF;
        ticks(12);
        checks++;
        if (bus.number !== 4'h6) begin
            errors++; $display("FAIL load_value: got %h expected %h", bus.number, 4'h6);
        end
        checks++;
        if (chg_cnt - c0 !== 1) begin
            errors++; $display("FAIL load_pulses: got %0d expected 1", chg_cnt - c0);
        end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = chg_cnt;
        for (int r = 0; r < 5; r++) begin
            bus.KEY[1] = 1'b0;
            ticks(2);
            bus.KEY[1] = 1'b1;
            ticks(2);
        end
        ticks(10);
        checks++;
        if (chg_cnt - c0 !== 0) begin
            errors++; $display("FAIL glitch_pulses: got %0d expected 0", chg_cnt - c0);
        end
        checks++;
        if (bus.number !== 4'h6) begin
            errors++; $display("FAIL glitch_number: got %h expected %h", bus.number, 4'h6);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int c0;
        do_reset();
        bus.KEY[0] = 1'b0;
        ticks(35);
        checks++;
        if (bus.number !== 4'hC) begin
            errors++; $display("FAIL midrep_pre: got %h expected %h", bus.number, 4'hC);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.number !== 4'hF || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL midrep_async: got number %h changed %b expected number f changed 0",
                     bus.number, bus.changed);
        end
        ticks(3);
        rst = 1'b0;
        c0 = chg_cnt;
        ticks(40);
        checks++;
        if (chg_cnt - c0 !== 0 || bus.number !== 4'hF) begin
            errors++;
            $display("FAIL midrep_held: got number %h pulses %0d expected number f pulses 0",
                     bus.number, chg_cnt - c0);
        end
        bus.KEY[0] = 1'b1;
        ticks(10);
        c0 = chg_cnt;
        press(0, 10);
        checks++;
        if (bus.number !== 4'hE || chg_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL midrep_repress: got number %h pulses %0d expected number e pulses 1",
                     bus.number, chg_cnt - c0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.KEY = 4'hF;
        bus.SW  = 4'h0;
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_wrap();
        test_load_priority();
        test_glitch();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
